md5_round_ctrl: RTL and testbench

//  Sequences one MD5 compression (64 steps) per accepted 512-bit block. Drives the 6-bit step

---
 rtl/md5_round_ctrl.sv | 105 ++++++++++
 tb/tb_md5_round_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md5_round_ctrl.sv
// MD5 compression sequencer: one LOAD, 64 RUN steps and one FINAL per accepted block.
// Optional `MD5_STALL_EN adds a step_hold input that freezes stepping during RUN.
module md5_round_ctrl #(
  parameter int BLK_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 blk_valid,
  input  logic                 blk_last,
  output logic                 blk_ready,
  output logic [5:0]           step_idx,
  output logic [3:0]           msg_sel,
  output logic [1:0]           func_sel,
  output logic                 load_en,
  output logic                 iv_sel,
  output logic                 step_en,
  output logic                 final_en,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic [BLK_CNT_W-1:0] blk_count
`ifdef MD5_STALL_EN
  ,
  input  logic                 step_hold
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_FINAL, S_DONE} state_t;

  state_t state, state_nxt;
  logic   first_blk;
  logic   last_q;
  logic   hold;

`ifdef MD5_STALL_EN
  assign hold = step_hold;
`else
  assign hold = 1'b0;
`endif

  // State register plus the per-block bookkeeping that moves with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      step_idx  <= '0;
      blk_count <= '0;
      first_blk <= 1'b1;
      last_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (blk_valid && blk_ready)
        last_q <= blk_last;
      if (state == S_LOAD)
        step_idx <= '0;
      else if (step_en)
        step_idx <= step_idx + 6'd1;
      if (state == S_FINAL)
        blk_count <= blk_count + BLK_CNT_W'(1);
      if (out_valid && out_ready) begin
        if (last_q) begin
          first_blk <= 1'b1;
          blk_count <= '0;
        end else begin
          first_blk <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (blk_valid && blk_ready) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_RUN;
      S_RUN:   if (step_en && step_idx == 6'd63) state_nxt = S_FINAL;
      S_FINAL: state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    blk_ready = (state == S_IDLE);
    load_en   = (state == S_LOAD);
    iv_sel    = (state == S_LOAD) && first_blk;
    step_en   = (state == S_RUN) && !hold;
    final_en  = (state == S_FINAL);
    out_valid = (state == S_DONE);
    out_last  = (state == S_DONE) && last_q;
  end

  // Message word schedule g, evaluated modulo 16 in 4-bit arithmetic
  always_comb begin
    msg_sel  = step_idx[3:0];
    func_sel = step_idx[5:4];
    unique case (step_idx[5:4])
      2'd0: msg_sel = step_idx[3:0];
      2'd1: msg_sel = step_idx[3:0] * 4'd5 + 4'd1;
      2'd2: msg_sel = step_idx[3:0] * 4'd3 + 4'd5;
      2'd3: msg_sel = step_idx[3:0] * 4'd7;
      default: msg_sel = step_idx[3:0];
    endcase
  end

endmodule

// File: tb/tb_md5_round_ctrl.sv
// Directed self-checking bench for md5_round_ctrl; stall scenario only with `MD5_STALL_EN.
module tb_md5_round_ctrl;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         blk_valid = 1'b0;
  logic         blk_last = 1'b0;
  logic         out_ready = 1'b0;
  logic         blk_ready, load_en, iv_sel, step_en, final_en, out_valid, out_last;
  logic [5:0]   step_idx;
  logic [3:0]   msg_sel;
  logic [1:0]   func_sel;
  logic [W-1:0] blk_count;
`ifdef MD5_STALL_EN
  logic         step_hold = 1'b0;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  md5_round_ctrl #(.BLK_CNT_W(W)) dut (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_last(blk_last), .blk_ready(blk_ready),
    .step_idx(step_idx), .msg_sel(msg_sel), .func_sel(func_sel), .load_en(load_en),
    .iv_sel(iv_sel), .step_en(step_en), .final_en(final_en), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .blk_count(blk_count)
`ifdef MD5_STALL_EN
    , .step_hold(step_hold)
`endif
  );

  wire [6:0] strb = {blk_ready, load_en, iv_sel, step_en, final_en, out_valid, out_last};

  function automatic logic [3:0] msg_model(input int i);
    int g;
    case (i / 16)
      0:       g = i;
      1:       g = 5 * i + 1;
      2:       g = 3 * i + 5;
      default: g = 7 * i;
    endcase
    return 4'(g % 16);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic last);
    blk_valid = 1'b1;
    blk_last  = last;
    tick();
    blk_valid = 1'b0;
    blk_last  = 1'b0;
  endtask

  // Sends one block, records iv_sel in LOAD, and stops in DONE with the edge count since accept
  task automatic run_block(input logic last, output logic iv, output int cyc);
    out_ready = 1'b0;
    send_block(last);
    iv  = iv_sel;
    cyc = 0;
    while (!out_valid && cyc < 300) begin
      tick();
      cyc++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vecs++;
    if (strb[5:0] !== 6'b0)
      $display("[TB] FAIL reset_strobes: got %b expected %b", strb[5:0], 6'b0);
    if (strb[5:0] !== 6'b0) errs++;
    vecs++;
    if ({step_idx, msg_sel, func_sel, blk_count} !== '0) begin
      $display("[TB] FAIL reset_idx: got step=%0d g=%0d f=%0d cnt=%0d expected all 0",
               step_idx, msg_sel, func_sel, blk_count);
      errs++;
    end
    rst = 1'b0;
    tick();
    vecs++;
    if (blk_ready !== 1'b1) begin
      $display("[TB] FAIL reset_ready: got %b expected 1", blk_ready);
      errs++;
    end
  endtask

  task automatic test_single_block();
    out_ready = 1'b0;
    send_block(1'b1);
    vecs++;
    if ({load_en, iv_sel, step_en, step_idx} !== {3'b110, 6'd0}) begin
      $display("[TB] FAIL load_cycle: got load=%b iv=%b step=%b idx=%0d expected 1 1 0 0",
               load_en, iv_sel, step_en, step_idx);
      errs++;
    end
    for (int k = 0; k < 64; k++) begin
      logic [5:0] k6;
      k6 = 6'(k);
      tick();
      vecs++;
      if ({step_en, step_idx, msg_sel, func_sel} !== {1'b1, k6, msg_model(k), k6[5:4]}) begin
        $display("[TB] FAIL run_step %0d: got en=%b idx=%0d g=%0d f=%0d expected 1 %0d %0d %0d",
                 k, step_en, step_idx, msg_sel, func_sel, k, msg_model(k), k6[5:4]);
        errs++;
      end
    end
    tick();
    vecs++;
    if ({final_en, step_en, out_valid, step_idx} !== {3'b100, 6'd0}) begin
      $display("[TB] FAIL final_cycle: got fin=%b en=%b ov=%b idx=%0d expected 1 0 0 0",
               final_en, step_en, out_valid, step_idx);
      errs++;
    end
    tick();
    vecs++;
    if ({out_valid, out_last, blk_ready, blk_count} !== {3'b110, W'(1)}) begin
      $display("[TB] FAIL done_cycle: got ov=%b ol=%b rdy=%b cnt=%0d expected 1 1 0 1",
               out_valid, out_last, blk_ready, blk_count);
      errs++;
    end
    handshake();
    vecs++;
    if ({out_valid, blk_ready, blk_count} !== {2'b01, W'(0)}) begin
      $display("[TB] FAIL after_last: got ov=%b rdy=%b cnt=%0d expected 0 1 0",
               out_valid, blk_ready, blk_count);
      errs++;
    end
  endtask

  task automatic test_msg_sel();
    int          idx  [10] = '{0, 16, 32, 48, 17, 20, 33, 47, 49, 63};
    logic [3:0]  gexp [10] = '{4'd0, 4'd1, 4'd5, 4'd0, 4'd6, 4'd5, 4'd8, 4'd2, 4'd7, 4'd9};
    logic [1:0]  fexp [10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    int          cyc;
    out_ready = 1'b0;
    send_block(1'b1);
    for (int k = 0; k < 64; k++) begin
      tick();
      for (int j = 0; j < 10; j++) begin
        if (idx[j] == k) begin
          vecs++;
          if ({msg_sel, func_sel} !== {gexp[j], fexp[j]}) begin
            $display("[TB] FAIL msg_sel step %0d: got g=%0d f=%0d expected g=%0d f=%0d",
                     k, msg_sel, func_sel, gexp[j], fexp[j]);
            errs++;
          end
        end
      end
    end
    cyc = 0;
    while (!out_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    handshake();
  endtask

  task automatic test_multi_block();
    logic        lasts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic        ivx   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] cntx [4] = '{W'(1), W'(2), W'(3), W'(1)};
    logic        iv;
    int          cyc;
    for (int b = 0; b < 4; b++) begin
      run_block(lasts[b], iv, cyc);
      vecs++;
      if ({iv, out_last, blk_count} !== {ivx[b], lasts[b], cntx[b]}) begin
        $display("[TB] FAIL multi_blk %0d: got iv=%b ol=%b cnt=%0d expected iv=%b ol=%b cnt=%0d",
                 b, iv, out_last, blk_count, ivx[b], lasts[b], cntx[b]);
        errs++;
      end
      vecs++;
      if (cyc !== 66) begin
        $display("[TB] FAIL latency blk %0d: got %0d expected 66", b, cyc);
        errs++;
      end
      handshake();
      if (b == 2) begin
        vecs++;
        if (blk_count !== W'(0)) begin
          $display("[TB] FAIL count_clear: got %0d expected 0", blk_count);
          errs++;
        end
      end
    end
  endtask

  task automatic test_back_pressure();
    logic iv;
    int   cyc;
    run_block(1'b1, iv, cyc);
    blk_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      vecs++;
      if ({out_valid, blk_ready, load_en} !== 3'b100) begin
        $display("[TB] FAIL hold_done %0d: got ov=%b rdy=%b load=%b expected 1 0 0",
                 k, out_valid, blk_ready, load_en);
        errs++;
      end
    end
    handshake();
    blk_valid = 1'b0;
    vecs++;
    if ({out_valid, blk_ready, load_en} !== 3'b010) begin
      $display("[TB] FAIL release_done: got ov=%b rdy=%b load=%b expected 0 1 0",
               out_valid, blk_ready, load_en);
      errs++;
    end
  endtask

  task automatic test_reset_mid();
    logic iv;
    int   cyc;
    logic seen;
    run_block(1'b0, iv, cyc);
    handshake();
    send_block(1'b0);
    cyc = 0;
    while (step_idx !== 6'd30 && cyc < 100) begin
      tick();
      cyc++;
    end
    vecs++;
    if (step_idx !== 6'd30) begin
      $display("[TB] FAIL reach_step30: got %0d expected 30", step_idx);
      errs++;
    end
    rst = 1'b1;
    tick();
    vecs++;
    if ({strb[5:0], step_idx, msg_sel, func_sel, blk_count} !== '0) begin
      $display("[TB] FAIL mid_reset: got strb=%b idx=%0d g=%0d f=%0d cnt=%0d expected all 0",
               strb[5:0], step_idx, msg_sel, func_sel, blk_count);
      errs++;
    end
    rst  = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    vecs++;
    if (seen !== 1'b0) begin
      $display("[TB] FAIL aborted_block: got out_valid=%b expected 0", seen);
      errs++;
    end
    run_block(1'b1, iv, cyc);
    vecs++;
    if ({iv, cyc == 66} !== 2'b11) begin
      $display("[TB] FAIL post_reset_blk: got iv=%b cyc=%0d expected iv=1 cyc=66", iv, cyc);
      errs++;
    end
    handshake();
  endtask

`ifdef MD5_STALL_EN
  task automatic test_stall();
    int cyc;
    out_ready = 1'b0;
    send_block(1'b1);
    cyc = 0;
    while (step_idx !== 6'd10 && cyc < 100) begin
      tick();
      cyc++;
    end
    step_hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      vecs++;
      if ({step_en, step_idx} !== {1'b0, 6'd10}) begin
        $display("[TB] FAIL stall %0d: got en=%b idx=%0d expected 0 10", k, step_en, step_idx);
        errs++;
      end
      tick();
      cyc++;
    end
    step_hold = 1'b0;
    while (!out_valid && cyc < 300) begin
      tick();
      cyc++;
    end
    vecs++;
    if (cyc !== 71) begin
      $display("[TB] FAIL stall_latency: got %0d expected 71", cyc);
      errs++;
    end
    handshake();
  endtask
`endif

  initial begin
    test_reset();
    test_single_block();
    test_msg_sel();
    test_multi_block();
    test_back_pressure();
    test_reset_mid();
`ifdef MD5_STALL_EN
    test_stall();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
